// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: job sequencer for a ROWS x COLS weight-stationary PE array.
// Loads weight rows, streams skewed activation vectors and tags each result with its index.
module pe_array_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 4,
    parameter int unsigned VW         = 8,
    parameter int unsigned ARRAY_LAT  = ROWS + COLS
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       keep_weights_i,
    input  logic [VW-1:0]              num_vecs_i,
    input  logic                       w_valid_i,
    output logic                       w_ready_o,
    input  logic [DATA_WIDTH*COLS-1:0] w_data_i,
    input  logic                       a_valid_i,
    output logic                       a_ready_o,
    input  logic [DATA_WIDTH*ROWS-1:0] a_data_i,
    output logic [DATA_WIDTH*COLS-1:0] pe_weight_o,
    output logic [ROWS-1:0]            pe_load_row_o,
    output logic [DATA_WIDTH*ROWS-1:0] pe_data_o,
    output logic [ROWS-1:0]            pe_data_valid_o,
    output logic                       res_valid_o,
    output logic [VW-1:0]              res_idx_o,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned WW = DATA_WIDTH * COLS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic                   busy_q, done_q, w_ready_q, a_ready_q;
    logic                   wts_resident_q;
    logic [VW-1:0]          nv_q, vec_cnt_q, res_cnt_q;
    logic [RW-1:0]          row_cnt_q;
    logic [WW-1:0]          pe_weight_q;
    logic [ROWS-1:0]        pe_load_row_q;
    logic [ARRAY_LAT-1:0]   vsr_q;
    logic                   w_acc_c, a_acc_c, last_row_c;

    assign w_acc_c    = w_valid_i && w_ready_q;
    assign a_acc_c    = a_valid_i && a_ready_q;
    assign last_row_c = (row_cnt_q == RW'(ROWS - 1));

    // Next-state decode; readies are registered from the next state so they line up with it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && (num_vecs_i != '0)) begin
                    state_d = (keep_weights_i && wts_resident_q) ? S_STREAM : S_LOAD;
                end
            end
            S_LOAD:   if (w_acc_c && last_row_c) state_d = S_STREAM;
            S_STREAM: if (a_acc_c && (vec_cnt_q == nv_q - VW'(1))) state_d = S_DRAIN;
            S_DRAIN:  if (vsr_q[ARRAY_LAT-2:0] == '0) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register, registered status/handshake outputs and job counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            w_ready_q      <= 1'b0;
            a_ready_q      <= 1'b0;
            wts_resident_q <= 1'b0;
            nv_q           <= '0;
            vec_cnt_q      <= '0;
            row_cnt_q      <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= (state_d != S_IDLE);
            done_q    <= (state_d == S_DONE);
            w_ready_q <= (state_d == S_LOAD);
            a_ready_q <= (state_d == S_STREAM);
            if ((state_q == S_IDLE) && (state_d != S_IDLE)) begin
                nv_q      <= num_vecs_i;
                vec_cnt_q <= '0;
                row_cnt_q <= '0;
            end
            if (w_acc_c) begin
                row_cnt_q <= last_row_c ? '0 : row_cnt_q + RW'(1);
                if (last_row_c) wts_resident_q <= 1'b1;
            end
            if (a_acc_c) vec_cnt_q <= vec_cnt_q + VW'(1);
        end
    end

    // Weight row register and one-hot row load strobe, one cycle after each accepted beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pe_weight_q   <= '0;
            pe_load_row_q <= '0;
        end else begin
            if (w_acc_c) pe_weight_q <= w_data_i;
            pe_load_row_q <= w_acc_c ? (ROWS'(1) << row_cnt_q) : '0;
        end
    end

    // In-flight token tracker: result valid ARRAY_LAT cycles after accept, indexed in order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vsr_q     <= '0;
            res_cnt_q <= '0;
        end else begin
            vsr_q <= ARRAY_LAT'({vsr_q, a_acc_c});
            if (state_q == S_DONE) begin
                res_cnt_q <= '0;
            end else if (vsr_q[ARRAY_LAT-1]) begin
                res_cnt_q <= res_cnt_q + VW'(1);
            end
        end
    end

    // Per-lane skew: lane r passes through r+1 stages; bubbles carry zero data.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        localparam int unsigned LW = (r + 1) * DATA_WIDTH;
        localparam int unsigned VD = r + 1;
        logic [LW-1:0]         d_q;
        logic [VD-1:0]         v_q;
        logic [DATA_WIDTH-1:0] lane_c;

        assign lane_c = a_acc_c ? a_data_i[r*DATA_WIDTH +: DATA_WIDTH] : '0;

        // Shift the lane data and its valid bit one stage per cycle.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                d_q <= '0;
                v_q <= '0;
            end else begin
                d_q <= LW'({d_q, lane_c});
                v_q <= VD'({v_q, a_acc_c});
            end
        end

        assign pe_data_o[r*DATA_WIDTH +: DATA_WIDTH] = d_q[LW-1 -: DATA_WIDTH];
        assign pe_data_valid_o[r]                    = v_q[VD-1];
    end

    assign w_ready_o     = w_ready_q;
    assign a_ready_o     = a_ready_q;
    assign pe_weight_o   = pe_weight_q;
    assign pe_load_row_o = pe_load_row_q;
    assign res_valid_o   = vsr_q[ARRAY_LAT-1];
    assign res_idx_o     = res_cnt_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Randomized bench for pe_array_sequencer against a cycle-timeline reference model.
module tb_pe_array_sequencer;

    localparam int unsigned DW   = 8;
    localparam int unsigned ROWS = 4;
    localparam int unsigned COLS = 4;
    localparam int unsigned VW   = 8;
    localparam int unsigned LAT  = ROWS + COLS;
    localparam int unsigned WW   = DW * COLS;
    localparam int unsigned AW   = DW * ROWS;
    localparam int          NEVER = 1 << 30;

    logic            clk, rst_ni;
    logic            start_i, keep_weights_i;
    logic [VW-1:0]   num_vecs_i;
    logic            w_valid_i, w_ready_o;
    logic [WW-1:0]   w_data_i;
    logic            a_valid_i, a_ready_o;
    logic [AW-1:0]   a_data_i;
    logic [WW-1:0]   pe_weight_o;
    logic [ROWS-1:0] pe_load_row_o;
    logic [AW-1:0]   pe_data_o;
    logic [ROWS-1:0] pe_data_valid_o;
    logic            res_valid_o;
    logic [VW-1:0]   res_idx_o;
    logic            busy_o, done_o;

    pe_array_sequencer #(
        .DATA_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .VW(VW), .ARRAY_LAT(LAT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .keep_weights_i (keep_weights_i),
        .num_vecs_i     (num_vecs_i),
        .w_valid_i      (w_valid_i),
        .w_ready_o      (w_ready_o),
        .w_data_i       (w_data_i),
        .a_valid_i      (a_valid_i),
        .a_ready_o      (a_ready_o),
        .a_data_i       (a_data_i),
        .pe_weight_o    (pe_weight_o),
        .pe_load_row_o  (pe_load_row_o),
        .pe_data_o      (pe_data_o),
        .pe_data_valid_o(pe_data_valid_o),
        .res_valid_o    (res_valid_o),
        .res_idx_o      (res_idx_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model: a job is a timeline of accepted beats keyed by cycle number.
    bit  job_active, need_load, resident;
    int  start_cyc, done_cyc, rows_done, n_acc, nv_m;
    int  wrow [int];
    logic [WW-1:0] wdat [int];
    logic [AW-1:0] accd [int];
    int  acci [int];
    bit  e_wr, e_ar;
    int  res_seen, done_seen;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit model_idle();
        return !job_active || (cyc > done_cyc);
    endfunction

    task automatic model_clear();
        job_active = 0; resident = 0; need_load = 0;
        start_cyc = 0; done_cyc = NEVER; rows_done = 0; n_acc = 0; nv_m = 0;
        wrow.delete(); wdat.delete(); accd.delete(); acci.delete();
        e_wr = 0; e_ar = 0;
    endtask

    // Advance one clock and compare every output with the model's expectation for the new cycle.
    task automatic tick_check();
        logic [ROWS-1:0] e_lr, e_pv;
        logic [AW-1:0]   e_pd, tmp;
        bit              act, e_rv;
        int              key;
        @(posedge clk);
        #1;
        cyc++;
        act  = job_active && (cyc > start_cyc) && (cyc <= done_cyc);
        e_wr = act && need_load && (rows_done < ROWS);
        e_ar = act && (!need_load || rows_done == ROWS) && (n_acc < nv_m);
        check_eq("busy", busy_o, act);
        check_eq("done", done_o, job_active && (cyc == done_cyc));
        check_eq("w_ready", w_ready_o, e_wr);
        check_eq("a_ready", a_ready_o, e_ar);
        e_lr = '0;
        if (wrow.exists(cyc - 1)) begin
            e_lr = ROWS'(1) << wrow[cyc - 1];
            check_eq("pe_weight", pe_weight_o, wdat[cyc - 1]);
        end
        check_eq("pe_load_row", pe_load_row_o, e_lr);
        e_pd = '0;
        e_pv = '0;
        for (int r = 0; r < ROWS; r++) begin
            key = cyc - 1 - r;
            if (accd.exists(key)) begin
                tmp = accd[key];
                e_pd[r*DW +: DW] = tmp[r*DW +: DW];
                e_pv[r] = 1'b1;
            end
        end
        check_eq("pe_data", pe_data_o, e_pd);
        check_eq("pe_data_valid", pe_data_valid_o, e_pv);
        key  = cyc - LAT;
        e_rv = accd.exists(key);
        check_eq("res_valid", res_valid_o, e_rv);
        if (e_rv) check_eq("res_idx", res_idx_o, acci[key]);
        if (res_valid_o === 1'b1) res_seen++;
        if (done_o === 1'b1) done_seen++;
    endtask

    // Drive one cycle of inputs, update the model with what the spec says gets accepted, then clock.
    task automatic cycle_drive(input bit st, input logic [VW-1:0] nv, input bit kw,
                               input bit wv, input logic [WW-1:0] wd,
                               input bit av, input logic [AW-1:0] ad);
        start_i = st; num_vecs_i = nv; keep_weights_i = kw;
        w_valid_i = wv; w_data_i = wd; a_valid_i = av; a_data_i = ad;
        if (st && (nv != '0) && model_idle()) begin
            job_active = 1; start_cyc = cyc; nv_m = int'(nv);
            need_load = !(kw && resident);
            rows_done = 0; n_acc = 0; done_cyc = NEVER;
        end
        if (wv && e_wr) begin
            wrow[cyc] = rows_done;
            wdat[cyc] = wd;
            rows_done++;
            if (rows_done == ROWS) resident = 1;
        end
        if (av && e_ar) begin
            accd[cyc] = ad;
            acci[cyc] = n_acc;
            n_acc++;
            if (n_acc == nv_m) done_cyc = cyc + LAT + 1;
        end
        tick_check();
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        start_i = 0; keep_weights_i = 0; num_vecs_i = '0;
        w_valid_i = 0; w_data_i = '0; a_valid_i = 0; a_data_i = '0;
        model_clear();
        @(posedge clk);
        #1;
        cyc++;
        check_eq("rst_w_ready", w_ready_o, 0);
        check_eq("rst_a_ready", a_ready_o, 0);
        check_eq("rst_pe_weight", pe_weight_o, 0);
        check_eq("rst_pe_load_row", pe_load_row_o, 0);
        check_eq("rst_pe_data", pe_data_o, 0);
        check_eq("rst_pe_data_valid", pe_data_valid_o, 0);
        check_eq("rst_res_valid", res_valid_o, 0);
        check_eq("rst_res_idx", res_idx_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_done", done_o, 0);
        rst_ni = 1'b1;
    endtask

    // wmode 1: continuous w_valid. amode 0: continuous, 1: random, 2: stall pattern 1,0,1,1,0,1.
    task automatic run_job(input int nv, input bit kw, input int wmode, input int amode,
                           input bit seq, input int stop_after);
        bit            wv, av, st;
        logic [WW-1:0] wd;
        logic [AW-1:0] ad;
        bit            pat [6];
        int            pi, n;
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        pi = 0;
        res_seen = 0;
        done_seen = 0;
        cycle_drive(1'b1, VW'(nv), kw, 1'b0, '0, 1'b0, '0);
        n = 0;
        while (!model_idle() && n < 6000) begin
            wv = (wmode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            wd = WW'($urandom);
            av = 1'b1;
            if (amode == 1) av = ($urandom_range(0, 2) != 0);
            if (amode == 2 && e_ar && pi < 6) begin
                av = pat[pi];
                pi++;
            end
            if (seq) begin
                for (int r = 0; r < ROWS; r++) ad[r*DW +: DW] = DW'(n_acc * 16 + r + 1);
            end else begin
                ad = AW'($urandom);
            end
            st = ($urandom_range(0, 7) == 0);
            cycle_drive(st, VW'($urandom), 1'($urandom_range(0, 1)), wv, wd, av, ad);
            n++;
            if (stop_after != 0 && n_acc >= stop_after) break;
        end
        if (n >= 6000) begin
            check_eq("job_timeout", 1, 0);
        end else if (stop_after == 0) begin
            check_eq("res_count", res_seen, nv);
            check_eq("done_count", done_seen, 1);
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        do_reset();
        run_job(5, 1'b0, 1, 0, 1'b0, 2);
        do_reset();
        run_job(3, 1'b0, 1, 0, 1'b1, 0);
        run_job(4, 1'b1, 0, 2, 1'b0, 0);
        run_job(2, 1'b1, 0, 0, 1'b0, 0);
        cycle_drive(1'b1, '0, 1'b0, 1'b0, '0, 1'b1, '0);
        repeat (3) cycle_drive(1'b0, '0, 1'b0, 1'b1, '0, 1'b1, '0);
        do_reset();
        run_job(2, 1'b1, 0, 1, 1'b0, 0);
        repeat (12) run_job($urandom_range(1, 20), 1'($urandom_range(0, 1)), 0, 1, 1'b0, 0);
        run_job(1, 1'b1, 0, 0, 1'b0, 0);
        run_job(1, 1'b0, 0, 1, 1'b0, 0);
        run_job(255, 1'b1, 0, 0, 1'b0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
